// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state codes and default sizes for bus_arbiter
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam int ARB_N_REQ  = 4;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_TMO    = 255;
  localparam int ARB_TMO_W  = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester and memory-bus signals seen by bus_arbiter
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ  = ARB_N_REQ,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  logic [N_REQ-1:0]        req_rd;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    err;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       addr_out;
  logic [DATA_W-1:0]       data_out;
  logic                    read_q;
  logic                    write_q;
  logic [DATA_W-1:0]       data_in;
  logic                    read_dn;
  logic                    write_dn;
  logic                    bus_busy;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata, data_in, read_dn, write_dn,
    output grant, done, err, rdata, addr_out, data_out, read_q, write_q, bus_busy
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata, data_in, read_dn, write_dn,
    input  grant, done, err, rdata, addr_out, data_out, read_q, write_q, bus_busy
  );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - first pending requester at or after ptr, with wrap
module bus_arbiter_rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!valid && pend[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner of the shared memory bus
// IDLE picks, GRANT drives the bus, WAIT holds until *_dn or timeout, DONE pulses done.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ  = ARB_N_REQ,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int TMO    = ARB_TMO
) (
  input logic           clk,
  input logic           rst,
  input logic           clk_oe,
  bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     owner;
  logic                 op_wr;
  logic [ARB_TMO_W-1:0] tmo_cnt;
  logic [N_REQ-1:0]     pend;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_wr;
  logic                 dn_hit;
  logic                 tmo_hit;

  assign pend    = bus.req_rd | bus.req_wr;
  assign pick_wr = bus.req_wr[pick_idx];
  assign dn_hit  = op_wr ? bus.write_dn : bus.read_dn;
  // Abort on the TMO-th WAIT cycle; the counter lands on TMO as DONE is entered.
  assign tmo_hit = (tmo_cnt == ARB_TMO_W'(TMO - 1));

  bus_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .pend  (pend),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      op_wr        <= 1'b0;
      tmo_cnt      <= '0;
      bus.grant    <= '0;
      bus.done     <= '0;
      bus.err      <= 1'b0;
      bus.rdata    <= '0;
      bus.addr_out <= '0;
      bus.data_out <= '0;
      bus.read_q   <= 1'b0;
      bus.write_q  <= 1'b0;
      bus.bus_busy <= 1'b0;
    end else if (clk_oe) begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state        <= ARB_GRANT;
            owner        <= pick_idx;
            op_wr        <= pick_wr;
            bus.grant    <= N_REQ'(1) << pick_idx;
            bus.bus_busy <= 1'b1;
            bus.addr_out <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
            bus.data_out <= pick_wr ? bus.req_wdata[pick_idx*DATA_W +: DATA_W] : '0;
            bus.read_q   <= !pick_wr;
            bus.write_q  <= pick_wr;
          end
        end
        ARB_GRANT: state <= ARB_WAIT;
        ARB_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (dn_hit || tmo_hit) begin
            state        <= ARB_DONE;
            bus.done     <= N_REQ'(1) << owner;
            bus.err      <= !dn_hit;
            bus.grant    <= '0;
            bus.bus_busy <= 1'b0;
            bus.addr_out <= '0;
            bus.data_out <= '0;
            bus.read_q   <= 1'b0;
            bus.write_q  <= 1'b0;
            if (dn_hit && !op_wr) bus.rdata <= bus.data_in;
          end
        end
        ARB_DONE: begin
          state    <= ARB_IDLE;
          bus.done <= '0;
          bus.err  <= 1'b0;
          tmo_cnt  <= '0;
          rr_ptr   <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [N-1:0]  grant;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gexp_t;

  typedef struct {
    logic [N-1:0]  done;
    logic          err;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  logic clk = 1'b0;
  logic rst;
  logic clk_oe;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [AW-1:0] addr_tab [N] = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 32'h0000_01C0};
  logic [DW-1:0] wdata_tab[N] = '{32'h0000_0011, 32'h0000_0055, 32'h0000_0033, 32'h0000_0044};

  bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TMO(255)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_oe (clk_oe),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int i, input bit wr, input logic [DW-1:0] rd,
                            input bit chk_rd, input bit err, input bit with_done);
    gexp_t g;
    dexp_t d;
    g.grant = N'(1) << i;
    g.wr    = wr;
    g.addr  = addr_tab[i];
    g.wdata = wr ? wdata_tab[i] : '0;
    gq.push_back(g);
    if (with_done) begin
      d.done   = N'(1) << i;
      d.err    = err;
      d.chk_rd = chk_rd;
      d.rdata  = rd;
      dq.push_back(d);
    end
  endtask

  task automatic monitor();
    logic [N-1:0] pg;
    logic [N-1:0] pd;
    gexp_t g;
    dexp_t d;
    pg = '0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.grant != '0 && pg == '0) begin
          if (gq.size() == 0) check("unexpected_grant", 64'(bus.grant), 64'(0));
          else begin
            g = gq.pop_front();
            check("grant", 64'(bus.grant), 64'(g.grant));
            check("strobes", 64'({bus.bus_busy, bus.read_q, bus.write_q}), 64'({1'b1, ~g.wr, g.wr}));
            check("addr_out", 64'(bus.addr_out), 64'(g.addr));
            check("data_out", 64'(bus.data_out), 64'(g.wdata));
          end
        end
        if (bus.done != '0 && pd == '0) begin
          if (dq.size() == 0) check("unexpected_done", 64'(bus.done), 64'(0));
          else begin
            d = dq.pop_front();
            check("done", 64'(bus.done), 64'(d.done));
            check("err", 64'(bus.err), 64'(d.err));
            if (d.chk_rd) check("rdata", 64'(bus.rdata), 64'(d.rdata));
            check("done_bus_idle", 64'({bus.grant, bus.bus_busy, bus.read_q, bus.write_q}), 64'(0));
            check("done_bus_zero", {bus.addr_out, bus.data_out}, 64'(0));
          end
        end
      end
      pg = bus.grant;
      pd = bus.done;
    end
  endtask

  task automatic tick(input bit gate);
    @(negedge clk);
    if (gate) clk_oe = ~clk_oe;
  endtask

  task automatic wait_strobe(input bit gate, output int t, output bit ok);
    int n;
    n = 0;
    while (!(bus.read_q || bus.write_q) && n < 60) begin
      tick(gate);
      n++;
    end
    check("strobe_seen", 64'(bus.read_q | bus.write_q), 64'(1));
    ok = bus.read_q | bus.write_q;
    t  = cyc;
  endtask

  task automatic serve(input int dly, input bit wr, input logic [DW-1:0] rd,
                       input bit stray, input bit gate, output int t);
    int n;
    bit ok;
    wait_strobe(gate, t, ok);
    if (!ok) return;
    repeat (dly) tick(gate);
    if (stray) begin
      if (wr) bus.read_dn = 1'b1;
      else    bus.write_dn = 1'b1;
      tick(gate);
      bus.read_dn  = 1'b0;
      bus.write_dn = 1'b0;
      check("stray_dn_ignored", 64'(bus.done), 64'(0));
    end
    bus.data_in = rd;
    if (wr) bus.write_dn = 1'b1;
    else    bus.read_dn  = 1'b1;
    n = 0;
    while (bus.done == '0 && n < 60) begin
      tick(gate);
      n++;
    end
    check("done_seen", 64'(bus.done != '0), 64'(1));
    if (!gate) check("dn_to_done_latency", 64'(n), 64'(1));
    bus.read_dn  = 1'b0;
    bus.write_dn = 1'b0;
    bus.data_in  = '0;
  endtask

  initial begin
    int  t;
    int  tp;
    int  n;
    bit  ok;
    rst           = 1'b0;
    clk_oe        = 1'b1;
    bus.req_rd    = '0;
    bus.req_wr    = '0;
    bus.data_in   = '0;
    bus.read_dn   = 1'b0;
    bus.write_dn  = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = addr_tab[i];
      bus.req_wdata[i*DW +: DW] = wdata_tab[i];
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({bus.grant, bus.done, bus.err, bus.read_q, bus.write_q, bus.bus_busy}), 64'(0));
    check("reset_bus", {bus.addr_out, bus.data_out}, 64'(0));
    check("reset_rdata", 64'(bus.rdata), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // fairness from pointer 0
    for (int k = 0; k < 5; k++) expect_txn(k % N, 1'b0, DW'(32'h1000 + k), 1'b1, 1'b0, 1'b1);
    bus.req_rd = 4'b1111;
    tp = 0;
    for (int k = 0; k < 5; k++) begin
      serve(1, 1'b0, DW'(32'h1000 + k), 1'b0, 1'b0, t);
      if (k == 4) bus.req_rd = '0;
      if (k > 0) check("fair_gap", 64'(t - tp), 64'(4));
      tp = t;
    end

    // single read on requester 2, then pointer sits at 3
    @(negedge clk);
    expect_txn(2, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    bus.req_rd = 4'b0100;
    serve(3, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, t);
    bus.req_rd = '0;
    @(negedge clk);
    expect_txn(3, 1'b0, 32'hA5A5_0003, 1'b1, 1'b0, 1'b1);
    expect_txn(0, 1'b0, 32'hA5A5_0000, 1'b1, 1'b0, 1'b1);
    bus.req_rd = 4'b1001;
    serve(2, 1'b0, 32'hA5A5_0003, 1'b0, 1'b0, t);
    bus.req_rd = 4'b0001;
    serve(1, 1'b0, 32'hA5A5_0000, 1'b0, 1'b0, t);
    bus.req_rd = '0;

    // write wins over read on the same requester
    @(negedge clk);
    expect_txn(1, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    bus.req_rd = 4'b0010;
    bus.req_wr = 4'b0010;
    serve(1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, t);
    bus.req_rd = '0;
    bus.req_wr = '0;
    check("rdata_hold_on_write", 64'(bus.rdata), 64'(32'hA5A5_0000));

    // timeout abort on requester 0
    @(negedge clk);
    expect_txn(0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    bus.req_rd = 4'b0001;
    wait_strobe(1'b0, t, ok);
    n = 0;
    while (bus.done == '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 64'(cyc - t), 64'(256));
    bus.req_rd = '0;
    @(negedge clk);
    check("after_timeout_idle", 64'({bus.bus_busy, bus.err, bus.done}), 64'(0));

    // asynchronous reset in WAIT on requester 1
    @(negedge clk);
    expect_txn(1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    bus.req_rd = 4'b0010;
    wait_strobe(1'b0, t, ok);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    #1 check("reset_mid_wait", 64'({bus.grant, bus.bus_busy, bus.read_q, bus.write_q, bus.done}), 64'(0));
    bus.req_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_txn(0, 1'b0, 32'h0000_5A00, 1'b1, 1'b0, 1'b1);
    expect_txn(2, 1'b0, 32'h0000_5A02, 1'b1, 1'b0, 1'b1);
    bus.req_rd = 4'b0101;
    serve(1, 1'b0, 32'h0000_5A00, 1'b0, 1'b0, t);
    bus.req_rd = 4'b0100;
    serve(2, 1'b0, 32'h0000_5A02, 1'b0, 1'b0, t);
    bus.req_rd = '0;

    // clock-enable gating: frozen IDLE, then toggled enable through a read
    @(negedge clk);
    expect_txn(2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
    clk_oe     = 1'b0;
    bus.req_rd = 4'b0100;
    repeat (4) @(negedge clk);
    check("frozen_no_grant", 64'(bus.grant), 64'(0));
    serve(3, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, t);
    clk_oe     = 1'b1;
    bus.req_rd = '0;

    // long freeze in WAIT must not age the timeout
    @(negedge clk);
    expect_txn(3, 1'b0, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1);
    bus.req_rd = 4'b1000;
    wait_strobe(1'b0, t, ok);
    @(negedge clk);
    clk_oe = 1'b0;
    repeat (254) @(negedge clk);
    check("frozen_wait_held", 64'({bus.grant, bus.read_q, bus.bus_busy, bus.done}), 64'({4'b1000, 1'b1, 1'b1, 4'b0000}));
    clk_oe = 1'b1;
    serve(1, 1'b0, 32'h0BAD_CAFE, 1'b0, 1'b0, t);
    bus.req_rd = '0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(gq.size() + dq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
